// File: rtl/wired_lsu_pipe_pkg.sv
// wired_lsu_pipe_pkg
// Shared types and constants for the LSU execution stage. Holds the
// IQ-side request/response structs, the dcache port structs, the
// tracking-FIFO entry, the msize encoding, the ALE exception code and the
// misalignment helper.
package wired_lsu_pipe_pkg;

  localparam int unsigned WID_W = 4;

  // Access size encoding carried in msize
  localparam logic [1:0] MSIZE_BYTE = 2'd0;
  localparam logic [1:0] MSIZE_HALF = 2'd1;
  localparam logic [1:0] MSIZE_WORD = 2'd2;

  // Address-misaligned exception code
  localparam logic [5:0] ECODE_ALE = 6'h09;

  typedef enum logic [2:0] {
    CACOP_NONE               = 3'd0,
    CACOP_IDX_INIT           = 3'd1,
    CACOP_IDX_INV            = 3'd2,
    CACOP_HIT_INV            = 3'd3,
    CACOP_NOT_VALID_INV_PARM = 3'd4
  } cacop_e;

  typedef struct packed {
    logic        valid;
    logic [5:0]  ecode;
    logic [31:0] badv;
  } excp_t;

  typedef struct packed {
    logic [WID_W-1:0] wid;
    logic [31:0]      vaddr;
    logic [1:0]       msize;
    logic             msigned;
    logic [3:0]       strb;
    logic [31:0]      wdata;
    cacop_e           cacop;
    logic             dbar;
    logic             llsc;
  } iq_lsu_req_t;

  typedef struct packed {
    logic [WID_W-1:0] wid;
    logic [31:0]      vaddr;
    logic [31:0]      rdata;
    logic             uncached;
    excp_t            excp;
  } iq_lsu_resp_t;

  typedef struct packed {
    logic [31:0] vaddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    cacop_e      cacop;
    logic        dbar;
    logic        llsc;
  } lsu_dc_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        uncached;
    excp_t       excp;
  } lsu_dc_resp_t;

  // One entry per accepted request, kept until its response is consumed
  typedef struct packed {
    logic [WID_W-1:0] wid;
    logic [31:0]      vaddr;
    logic [1:0]       msize;
    logic             msigned;
    logic             ale;
  } lsu_track_t;

  // Cache maintenance ops and barriers ignore address alignment
  function automatic logic lsu_misaligned(input iq_lsu_req_t r);
    logic result;
    result = 1'b0;
    if (!(r.dbar || (r.cacop inside {CACOP_IDX_INIT, CACOP_IDX_INV,
                                     CACOP_HIT_INV, CACOP_NOT_VALID_INV_PARM}))) begin
      if (r.msize == MSIZE_WORD) result = (r.vaddr[1:0] != 2'b00);
      else if (r.msize == MSIZE_HALF) result = r.vaddr[0];
    end
    return result;
  endfunction

endpackage

// File: rtl/wired_fifo.sv
// wired_fifo
// Synchronous FIFO with registered occupancy count. Full/empty are derived
// from the registered count only, so a pop in a full cycle does not make
// room for a push in that same cycle.
// Ports: clk, rst_n (sync, active-low), push_i/data_i, pop_i,
//        data_o (head), empty_o, full_o.
module wired_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic                  push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally; occupancy is tracked in its own counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only slots below count are ever read
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wired_lsu_pipe_ldext.sv
// wired_lsu_ldext
// Load-data extraction: selects the addressed byte/half from the raw
// 32-bit dcache word and sign- or zero-extends it. Words pass through.
// Ports: raw_i (dcache word), offset_i (vaddr[1:0]), msize_i, msigned_i,
//        rdata_o (aligned, extended load data).
module wired_lsu_ldext
  import wired_lsu_pipe_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  msize_i,
  input  logic        msigned_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = 8'(raw_i >> {offset_i, 3'b000});
  assign half_v = 16'(raw_i >> {offset_i[1], 4'b0000});

  // Extend by access size; unknown sizes are treated as a full word
  always_comb begin
    rdata_o = raw_i;
    case (msize_i)
      MSIZE_BYTE: rdata_o = {{24{msigned_i & byte_v[7]}}, byte_v};
      MSIZE_HALF: rdata_o = {{16{msigned_i & half_v[15]}}, half_v};
      default:    rdata_o = raw_i;
    endcase
  end

endmodule

// File: rtl/wired_lsu_pipe.sv
// wired_lsu_pipe
// In-order load/store execution stage between the LSU issue queue and the
// dcache port. Misaligned accesses are trapped locally as ALE; aligned ones
// go to the dcache. Every accepted request is tracked in a FIFO so that
// responses return strictly in issue order. After a flush, dcache responses
// still in flight are drained and discarded.
// Ports: clk, rst_n (sync, active-low), flush_i,
//        req_valid_i/req_ready_o/req_i      : requests from the IQ
//        resp_valid_o/resp_ready_i/resp_o   : responses to the IQ
//        dc_req_valid_o/dc_req_ready_i/dc_req_o    : dcache request
//        dc_resp_valid_i/dc_resp_ready_o/dc_resp_i : dcache response
module wired_lsu_pipe
  import wired_lsu_pipe_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  iq_lsu_req_t  req_i,
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output iq_lsu_resp_t resp_o,
  output logic         dc_req_valid_o,
  input  logic         dc_req_ready_i,
  output lsu_dc_req_t  dc_req_o,
  input  logic         dc_resp_valid_i,
  output logic         dc_resp_ready_o,
  input  lsu_dc_resp_t dc_resp_i
);

  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             misaligned, accept_ok, draining;
  logic             req_fire, dc_req_fire, dc_resp_fire, pop;
  logic             fifo_empty, fifo_full, fifo_rst_n;
  lsu_track_t       push_entry, head;
  logic [31:0]      ext_rdata;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  assign misaligned = lsu_misaligned(req_i);
  assign draining   = (drop_q != '0);
  assign accept_ok  = !flush_i && !fifo_full && !draining;

  assign dc_req_valid_o = req_valid_i && accept_ok && !misaligned;
  assign req_ready_o    = accept_ok && (misaligned || dc_req_ready_i);

  assign dc_req_o.vaddr = req_i.vaddr;
  assign dc_req_o.wdata = req_i.wdata;
  assign dc_req_o.strb  = req_i.strb;
  assign dc_req_o.cacop = req_i.cacop;
  assign dc_req_o.dbar  = req_i.dbar;
  assign dc_req_o.llsc  = req_i.llsc;

  assign req_fire     = req_valid_i && req_ready_o;
  assign dc_req_fire  = dc_req_valid_o && dc_req_ready_i;
  assign dc_resp_fire = dc_resp_valid_i && dc_resp_ready_o;
  assign pop          = resp_valid_o && resp_ready_i;

  assign push_entry.wid     = req_i.wid;
  assign push_entry.vaddr   = req_i.vaddr;
  assign push_entry.msize   = req_i.msize;
  assign push_entry.msigned = req_i.msigned;
  assign push_entry.ale     = misaligned;

  // A flush empties the tracking queue at the next edge
  assign fifo_rst_n = rst_n && !flush_i;

  wired_fifo #(
    .DATA_WIDTH ($bits(lsu_track_t)),
    .DEPTH      (MAX_INFLIGHT)
  ) u_track_fifo (
    .clk     (clk),
    .rst_n   (fifo_rst_n),
    .push_i  (req_fire),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  wired_lsu_ldext u_ldext (
    .raw_i     (dc_resp_i.rdata),
    .offset_i  (head.vaddr[1:0]),
    .msize_i   (head.msize),
    .msigned_i (head.msigned),
    .rdata_o   (ext_rdata)
  );

  // Response steering: flush and drain swallow dcache responses; otherwise
  // the FIFO head decides between a local ALE and the dcache result.
  always_comb begin
    resp_valid_o    = 1'b0;
    dc_resp_ready_o = 1'b0;
    resp_o          = '0;
    resp_o.wid      = head.wid;
    resp_o.vaddr    = head.vaddr;
    if (flush_i || draining) begin
      dc_resp_ready_o = 1'b1;
    end else if (!fifo_empty) begin
      if (head.ale) begin
        resp_valid_o      = 1'b1;
        resp_o.excp.valid = 1'b1;
        resp_o.excp.ecode = ECODE_ALE;
        resp_o.excp.badv  = head.vaddr;
      end else begin
        resp_valid_o    = dc_resp_valid_i;
        dc_resp_ready_o = resp_ready_i;
        resp_o.uncached = dc_resp_i.uncached;
        resp_o.excp     = dc_resp_i.excp;
        resp_o.rdata    = dc_resp_i.excp.valid ? dc_resp_i.rdata : ext_rdata;
      end
    end
  end

  // Outstanding dcache traffic and the number of responses left to discard.
  // No dcache request can fire during a flush, so only the response term
  // adjusts the drop count captured there.
  always_comb begin
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (dc_req_fire && !dc_resp_fire)      inflight_d = inflight_q + CNT_ONE;
    else if (!dc_req_fire && dc_resp_fire) inflight_d = inflight_q - CNT_ONE;
    if (flush_i)                      drop_d = inflight_q - CNT_W'(dc_resp_fire);
    else if (draining && dc_resp_fire) drop_d = drop_q - CNT_ONE;
  end

  // Counter registers; the dcache resets alongside this block
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // A dcache response with nothing outstanding is a protocol violation
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(dc_resp_valid_i && (inflight_q == '0)));

endmodule

// File: tb/tb_wired_lsu_pipe.sv
// tb_wired_lsu_pipe
// Directed bench for wired_lsu_pipe: byte/half extraction, in-order ALE,
// backpressure at full occupancy, flush drain, cacop bypass and dcache
// exception pass-through.
module tb_wired_lsu_pipe;
  import wired_lsu_pipe_pkg::*;

  logic         clk;
  logic         rstN;
  logic         flush;
  logic         reqValid;
  logic         reqReady;
  iq_lsu_req_t  req;
  logic         respValid;
  logic         respReady;
  iq_lsu_resp_t resp;
  logic         dcReqValid;
  logic         dcReqReady;
  lsu_dc_req_t  dcReq;
  logic         dcRespValid;
  logic         dcRespReady;
  lsu_dc_resp_t dcResp;

  int checks = 0;
  int passes = 0;

  wired_lsu_pipe #(.MAX_INFLIGHT(4)) dut (
    .clk             (clk),
    .rst_n           (rstN),
    .flush_i         (flush),
    .req_valid_i     (reqValid),
    .req_ready_o     (reqReady),
    .req_i           (req),
    .resp_valid_o    (respValid),
    .resp_ready_i    (respReady),
    .resp_o          (resp),
    .dc_req_valid_o  (dcReqValid),
    .dc_req_ready_i  (dcReqReady),
    .dc_req_o        (dcReq),
    .dc_resp_valid_i (dcRespValid),
    .dc_resp_ready_o (dcRespReady),
    .dc_resp_i       (dcResp)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck simulation
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    else
      passes++;
  endtask

  task automatic applyStimulus(input logic valid, input logic [WID_W-1:0] wid,
                               input logic [31:0] vaddr, input logic [1:0] msize,
                               input logic msigned, input cacop_e cacop);
    req         = '0;
    reqValid    = valid;
    req.wid     = wid;
    req.vaddr   = vaddr;
    req.msize   = msize;
    req.msigned = msigned;
    req.cacop   = cacop;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setDcResp(input logic valid, input logic [31:0] raw, input logic excpValid);
    dcRespValid        = valid;
    dcResp             = '0;
    dcResp.rdata       = raw;
    dcResp.excp.valid  = excpValid;
    dcResp.excp.ecode  = excpValid ? 6'h01 : 6'h00;
    dcResp.excp.badv   = excpValid ? 32'h0000_8001 : 32'h0;
  endtask

  // Present one request, confirm acceptance, take it and go idle
  task automatic issue(input string tag, input logic [WID_W-1:0] wid,
                       input logic [31:0] vaddr, input logic [1:0] msize,
                       input logic msigned);
    applyStimulus(1'b1, wid, vaddr, msize, msigned, CACOP_NONE);
    #1;
    checkOutput(tag, 64'(reqReady), 64'd1);
    tick();
    applyStimulus(1'b0, '0, 32'h0, MSIZE_WORD, 1'b0, CACOP_NONE);
  endtask

  initial begin
    rstN       = 1'b0;
    flush      = 1'b0;
    respReady  = 1'b1;
    dcReqReady = 1'b1;
    applyStimulus(1'b0, '0, 32'h0, MSIZE_WORD, 1'b0, CACOP_NONE);
    setDcResp(1'b0, 32'h0, 1'b0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_resp_valid", 64'(respValid), 64'd0);
    checkOutput("rst_dc_resp_ready", 64'(dcRespReady), 64'd0);
    rstN = 1'b1;
    #1;
    checkOutput("rst_req_ready", 64'(reqReady), 64'd1);
    checkOutput("rst_dc_req_valid", 64'(dcReqValid), 64'd0);
    checkOutput("rst_resp_valid_after", 64'(respValid), 64'd0);
    tick();

    // Signed byte load
    applyStimulus(1'b1, 4'd5, 32'h0000_1003, MSIZE_BYTE, 1'b1, CACOP_NONE);
    #1;
    checkOutput("sb_dc_req_valid", 64'(dcReqValid), 64'd1);
    checkOutput("sb_dc_req_vaddr", 64'(dcReq.vaddr), 64'h1003);
    tick();
    applyStimulus(1'b0, '0, 32'h0, MSIZE_WORD, 1'b0, CACOP_NONE);
    setDcResp(1'b1, 32'h80FF_1234, 1'b0);
    #1;
    checkOutput("sb_resp_valid", 64'(respValid), 64'd1);
    checkOutput("sb_rdata", 64'(resp.rdata), 64'hFFFF_FF80);
    checkOutput("sb_wid", 64'(resp.wid), 64'd5);
    checkOutput("sb_dc_resp_ready", 64'(dcRespReady), 64'd1);
    tick();
    setDcResp(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("sb_resp_idle", 64'(respValid), 64'd0);

    // Half loads, unsigned then signed, back to back
    issue("lh_acc0", 4'd1, 32'h0000_2002, MSIZE_HALF, 1'b0);
    issue("lh_acc1", 4'd2, 32'h0000_2002, MSIZE_HALF, 1'b1);
    setDcResp(1'b1, 32'hBEEF_0000, 1'b0);
    #1;
    checkOutput("lhu_rdata", 64'(resp.rdata), 64'h0000_BEEF);
    checkOutput("lhu_wid", 64'(resp.wid), 64'd1);
    tick();
    checkOutput("lhs_rdata", 64'(resp.rdata), 64'hFFFF_BEEF);
    checkOutput("lhs_wid", 64'(resp.wid), 64'd2);
    tick();
    setDcResp(1'b0, 32'h0, 1'b0);

    // Misaligned word behind a pending aligned load
    issue("mis_acc_al", 4'd3, 32'h0000_3000, MSIZE_WORD, 1'b0);
    applyStimulus(1'b1, 4'd4, 32'h0000_3001, MSIZE_WORD, 1'b0, CACOP_NONE);
    #1;
    checkOutput("mis_no_dc_req", 64'(dcReqValid), 64'd0);
    checkOutput("mis_req_ready", 64'(reqReady), 64'd1);
    checkOutput("mis_wait_head", 64'(respValid), 64'd0);
    tick();
    applyStimulus(1'b0, '0, 32'h0, MSIZE_WORD, 1'b0, CACOP_NONE);
    #1;
    checkOutput("mis_still_wait", 64'(respValid), 64'd0);
    setDcResp(1'b1, 32'h1122_3344, 1'b0);
    #1;
    checkOutput("mis_first_wid", 64'(resp.wid), 64'd3);
    checkOutput("mis_first_rdata", 64'(resp.rdata), 64'h1122_3344);
    tick();
    setDcResp(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("ale_valid", 64'(respValid), 64'd1);
    checkOutput("ale_wid", 64'(resp.wid), 64'd4);
    checkOutput("ale_excp", 64'(resp.excp.valid), 64'd1);
    checkOutput("ale_ecode", 64'(resp.excp.ecode), 64'(ECODE_ALE));
    checkOutput("ale_badv", 64'(resp.excp.badv), 64'h3001);
    checkOutput("ale_rdata", 64'(resp.rdata), 64'd0);
    tick();
    checkOutput("ale_popped", 64'(respValid), 64'd0);

    // Backpressure with four in flight
    respReady = 1'b0;
    for (int i = 0; i < 4; i++)
      issue("bp_acc", 4'(8 + i), 32'h0000_5000 + 32'(4 * i), MSIZE_WORD, 1'b0);
    applyStimulus(1'b1, 4'd12, 32'h0000_5010, MSIZE_WORD, 1'b0, CACOP_NONE);
    setDcResp(1'b1, 32'hA000_0000, 1'b0);
    #1;
    checkOutput("bp_req_ready", 64'(reqReady), 64'd0);
    checkOutput("bp_dc_req_valid", 64'(dcReqValid), 64'd0);
    checkOutput("bp_dc_resp_ready", 64'(dcRespReady), 64'd0);
    tick();
    checkOutput("bp_hold_valid", 64'(respValid), 64'd1);
    checkOutput("bp_hold_wid", 64'(resp.wid), 64'd8);
    applyStimulus(1'b0, '0, 32'h0, MSIZE_WORD, 1'b0, CACOP_NONE);
    respReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dcResp.rdata = 32'hA000_0000 + 32'(i);
      #1;
      checkOutput("bp_drain_wid", 64'(resp.wid), 64'(8 + i));
      checkOutput("bp_drain_rdata", 64'(resp.rdata), 64'hA000_0000 + 64'(i));
      tick();
    end
    setDcResp(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("bp_empty", 64'(respValid), 64'd0);

    // Flush with three in flight, then drain
    for (int i = 0; i < 3; i++)
      issue("fl_acc", 4'(i), 32'h0000_6000 + 32'(4 * i), MSIZE_WORD, 1'b0);
    flush = 1'b1;
    #1;
    checkOutput("fl_resp_valid", 64'(respValid), 64'd0);
    checkOutput("fl_dc_resp_ready", 64'(dcRespReady), 64'd1);
    checkOutput("fl_req_ready", 64'(reqReady), 64'd0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b1, 4'd9, 32'h0000_6100, MSIZE_WORD, 1'b0, CACOP_NONE);
    setDcResp(1'b1, 32'h5555_5555, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("drop_dc_resp_ready", 64'(dcRespReady), 64'd1);
      checkOutput("drop_resp_valid", 64'(respValid), 64'd0);
      checkOutput("drop_req_ready", 64'(reqReady), 64'd0);
      tick();
    end
    setDcResp(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("drop_done_ready", 64'(reqReady), 64'd1);
    checkOutput("drop_done_dc_req", 64'(dcReqValid), 64'd1);
    tick();
    applyStimulus(1'b0, '0, 32'h0, MSIZE_WORD, 1'b0, CACOP_NONE);
    setDcResp(1'b1, 32'h0BAD_F00D, 1'b0);
    #1;
    checkOutput("post_fl_wid", 64'(resp.wid), 64'd9);
    checkOutput("post_fl_rdata", 64'(resp.rdata), 64'h0BAD_F00D);
    tick();
    setDcResp(1'b0, 32'h0, 1'b0);

    // Cacop bypasses the alignment check
    applyStimulus(1'b1, 4'd7, 32'h0000_4001, MSIZE_WORD, 1'b0, CACOP_HIT_INV);
    #1;
    checkOutput("cacop_dc_req_valid", 64'(dcReqValid), 64'd1);
    checkOutput("cacop_req_ready", 64'(reqReady), 64'd1);
    tick();
    applyStimulus(1'b0, '0, 32'h0, MSIZE_WORD, 1'b0, CACOP_NONE);
    setDcResp(1'b1, 32'hCAFE_F00D, 1'b0);
    #1;
    checkOutput("cacop_resp_valid", 64'(respValid), 64'd1);
    checkOutput("cacop_no_ale", 64'(resp.excp.valid), 64'd0);
    checkOutput("cacop_wid", 64'(resp.wid), 64'd7);
    tick();
    setDcResp(1'b0, 32'h0, 1'b0);

    // Dcache exception passes raw data unshifted
    issue("dx_acc", 4'd6, 32'h0000_8001, MSIZE_BYTE, 1'b1);
    setDcResp(1'b1, 32'h1234_5678, 1'b1);
    #1;
    checkOutput("dx_rdata", 64'(resp.rdata), 64'h1234_5678);
    checkOutput("dx_excp", 64'(resp.excp.valid), 64'd1);
    checkOutput("dx_ecode", 64'(resp.excp.ecode), 64'h01);
    tick();
    setDcResp(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("dx_idle", 64'(respValid), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wired_lsu_pipe.md
# wired_lsu_pipe

In-order load/store execution stage between the LSU issue queue and the data cache port. It takes `iq_lsu_req_t` requests, traps misaligned accesses locally, and forwards aligned operations to the dcache. Cache and local results return strictly in issue order as `iq_lsu_resp_t`, with load data shifted and sign- or zero-extended. After a pipeline flush, the block drains and discards the dcache responses still in flight.

## Interface
- `MAX_INFLIGHT`, default 4: tracking FIFO depth, i.e. the maximum number of requests accepted but not yet responded (power of two, ≥2).
- `clk` in, 1: clock.
- `rst_n` in, 1: reset, synchronous, active-low.
- `flush_i` in, 1: backend flush; drops all tracked requests.
- `req_valid_i` in, 1: request valid from the IQ.
- `req_ready_o` out, 1: request accepted this cycle.
- `req_i` in, `iq_lsu_req_t`: request fields wid, vaddr, msize, msigned, strb, wdata, cacop, dbar, llsc.
- `resp_valid_o` out, 1: response valid toward the IQ commit FIFO.
- `resp_ready_i` in, 1: response consumed.
- `resp_o` out, `iq_lsu_resp_t`: response fields wid, vaddr, rdata, uncached, excp.
- `dc_req_valid_o` out, 1: dcache request valid.
- `dc_req_ready_i` in, 1: dcache request accepted.
- `dc_req_o` out, `lsu_dc_req_t`: vaddr, wdata, strb, cacop, dbar, llsc.
- `dc_resp_valid_i` in, 1: dcache response valid; responses arrive in request order.
- `dc_resp_ready_o` out, 1: dcache response consumed.
- `dc_resp_i` in, `lsu_dc_resp_t`: rdata (raw 32-bit word), uncached, excp.

## Operation
- **Misalignment check.** A request is misaligned when msize=2 and vaddr[1:0]≠0, or msize=1 and vaddr[0]=1. Requests with cacop ∈ {IDX_INIT, IDX_INV, HIT_INV, NOT_VALID_INV_PARM}, or with dbar set, are never misaligned.
- **Accept condition.** `accept_ok` = !flush_i && FIFO not full && drop_q==0.
  - `dc_req_valid_o` = req_valid_i && accept_ok && aligned.
  - `req_ready_o` = accept_ok && (misaligned || dc_req_ready_i).
  - `dc_req_o` is a combinational pass-through of `req_i`.
- **FIFO push.** On every request fire, push {wid, vaddr, msize, msigned, ale} into the tracking FIFO; ale=1 for misaligned requests.
- **Head with ale=1.** `resp_valid_o`=1 with no dcache involvement. `excp` = ALE with badv = vaddr; rdata=0; uncached=0.
- **Head with ale=0.** `resp_valid_o` = dc_resp_valid_i and `dc_resp_ready_o` = resp_ready_i. Response fields:
  - excp and uncached come from `dc_resp_i`.
  - rdata: byte = (raw >> {vaddr[1:0],3'b0})[7:0]; half = (raw >> {vaddr[1],4'b0})[15:0]; word = raw.
  - Extend byte/half to 32 bits with sign when msigned, zero otherwise.
  - When excp is valid, pass rdata through unshifted.
- **FIFO pop** happens on resp_valid_o && resp_ready_i.
- **In-flight counter.** `inflight_q` (width clog2(MAX_INFLIGHT)+1) increments on dc request fire and decrements on dc response fire. Both in one cycle leave it unchanged.
- **Flush.**
  - Empty the FIFO and deassert `resp_valid_o` for that cycle.
  - Set `drop_q` = inflight_q + dc_req fire − dc_resp fire. The dc_req fire term is 0, since accept is blocked during flush.
  - Set `dc_resp_ready_o`=1 in the flush cycle; a response arriving then is discarded.
- **Drop mode (drop_q>0).**
  - `dc_resp_ready_o`=1 and every dcache response is discarded, with `drop_q` decremented.
  - `resp_valid_o`=0 and no new request is accepted.
- **Errors.** A dcache response while inflight_q==0 is a protocol error; flag it with an assertion only.

## Timing
- **Reset values.** FIFO empty; inflight_q=0; drop_q=0. `resp_valid_o`=0 and `dc_resp_ready_o`=0. `dc_req_valid_o` and `req_ready_o` follow their combinational equations from the reset state.
- **Misaligned latency.** A misaligned request accepted in cycle N yields `resp_valid_o` in cycle N+1 at the earliest, if it is at the FIFO head.
- **Cache response path.** Response to `resp_o` is zero-cycle, combinational. An aligned request's response is visible in the same cycle `dc_resp_valid_i` rises, if that entry is at the head.
- **Throughput.** One request and one response per cycle, sustained.
- **Full FIFO.** A simultaneous pop does not free a slot in that cycle; push is gated on registered count < MAX_INFLIGHT.
- **Wrap-around.** FIFO pointers are clog2(MAX_INFLIGHT) bits and wrap naturally; the count is tracked separately.
- **Flush priority.** Flush overrides push and pop in the same cycle.
- **Reset mid-drop.** Clears `drop_q`; the dcache is assumed to be reset together with this block.

## Structure
- The shared package holds:
  - `lsu_dc_req_t` and `lsu_dc_resp_t`;
  - the ALE exception code constant;
  - the msize encoding: 0 byte, 1 half, 2 word.
- Reuse `wired_fifo` (DATA_WIDTH = tracking entry, DEPTH = MAX_INFLIGHT) for the tracking queue. Its reset is rst_n && !flush_i.
- Load-data extraction is one natural combinational sub-module: `wired_lsu_ldext`, taking (raw, vaddr[1:0], msize, msigned) and producing rdata.

## Test plan
- **Signed byte load.** vaddr=0x1003, msize=0, msigned=1; dcache raw 0x80FF_1234 → rdata 0xFFFF_FF80, wid preserved.
- **Half loads.** vaddr=0x2002, msize=1, raw 0xBEEF_0000; msigned=0 → 0x0000_BEEF; msigned=1 → 0xFFFF_BEEF.
- **Misaligned word in order.** Word load at 0x3001 issued behind an aligned load still waiting on the dcache → no dc request for it. ALE response (badv 0x3001) appears only after the aligned load's response.
- **Backpressure.** dc_resp_ready held low via resp_ready_i=0 with 4 requests in flight → req_ready_o=0 and the FIFO holds. Releasing it returns 4 responses in order, one per cycle.
- **Flush during drain.** Flush with 3 requests in flight → drop_q=3. The next 3 dcache responses are consumed and produce no resp_valid_o. req_ready_o stays 0 until the third is dropped, then returns to 1.
- **Cacop bypass.** HIT_INV cacop with vaddr=0x4001 → forwarded to the dcache, not flagged as ALE.
